// File: rtl/hazard_ctrl_if.sv
// Bundle of ID/EX hazard inputs and pipeline-control outputs for hazard_ctrl.
// The master side drives the decode/execute status; the slave side is the controller.
interface hazard_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [ADDR_W-1:0] ex_rd;
    logic              ex_memread;
    logic              ex_branch_taken;
    logic              ex_mc_start;
    logic              mc_done;
    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_write;
    logic              control_sel;
    logic              if_id_flush;
    logic [CNT_W-1:0]  stall_cycles;
    logic              mc_timeout;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_branch_taken, ex_mc_start, mc_done,
        input  pc_write, if_id_write, id_ex_write, control_sel, if_id_flush,
               stall_cycles, mc_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_branch_taken, ex_mc_start, mc_done,
        output pc_write, if_id_write, id_ex_write, control_sel, if_id_flush,
               stall_cycles, mc_timeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multi-cycle load-use stalls, taken-branch flush,
// multi-cycle EX-unit wait with timeout, and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int LOAD_LAT   = 1,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    localparam int          TO_W   = (MC_TIMEOUT > 0) ? $clog2(MC_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MC_TIMEOUT);
    localparam logic [3:0]  LL_M1  = 4'(LOAD_LAT - 1);

    typedef enum logic [1:0] {IDLE, LOAD_STALL, MC_WAIT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q;

    logic hit;
    logic pc_wr, ifid_wr, idex_wr, ctl_sel, ifid_fl;

    assign hit = hz.ex_memread && (hz.ex_rd != '0) &&
                 ((hz.id_use_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                  (hz.id_use_rs2 && (hz.ex_rd == hz.id_rs2)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        timeout_d = timeout_q;
        pc_wr     = 1'b1;
        ifid_wr   = 1'b1;
        idex_wr   = 1'b1;
        ctl_sel   = 1'b0;
        ifid_fl   = 1'b0;

        case (state_q)
            IDLE: begin
                // A multi-cycle op that completes immediately needs no stall.
                if (hz.ex_mc_start && !hz.mc_done) begin
                    pc_wr   = 1'b0;
                    ifid_wr = 1'b0;
                    idex_wr = 1'b0;
                    ctl_sel = 1'b1;
                    to_d    = '0;
                    state_d = MC_WAIT;
                end else if (hz.ex_branch_taken) begin
                    ifid_fl = 1'b1;
                    ctl_sel = 1'b1;
                end else if (hit) begin
                    pc_wr   = 1'b0;
                    ifid_wr = 1'b0;
                    ctl_sel = 1'b1;
                    if (LOAD_LAT > 1) begin
                        cnt_d   = LL_M1;
                        state_d = LOAD_STALL;
                    end
                end
            end
            LOAD_STALL: begin
                pc_wr   = 1'b0;
                ifid_wr = 1'b0;
                ctl_sel = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            MC_WAIT: begin
                if (hz.mc_done) begin
                    state_d = IDLE;
                end else begin
                    pc_wr   = 1'b0;
                    ifid_wr = 1'b0;
                    idex_wr = 1'b0;
                    ctl_sel = 1'b1;
                    to_d    = to_q + TO_W'(1);
                    if ((MC_TIMEOUT != 0) && (to_d == TO_LIM)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset overrides the outputs immediately, not at the next edge.
        if (!rst_n) begin
            pc_wr   = 1'b0;
            ifid_wr = 1'b0;
            idex_wr = 1'b0;
            ctl_sel = 1'b1;
            ifid_fl = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            to_q      <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            timeout_q <= timeout_d;
            if (!pc_wr && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign hz.pc_write     = pc_wr;
    assign hz.if_id_write  = ifid_wr;
    assign hz.id_ex_write  = idex_wr;
    assign hz.control_sel  = ctl_sel;
    assign hz.if_id_flush  = ifid_fl;
    assign hz.stall_cycles = stall_q;
    assign hz.mc_timeout   = timeout_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT=3/MC_TIMEOUT=8/CNT_W=16 and
// LOAD_LAT=1/no timeout/CNT_W=2) share stimulus and are checked against a cycle model.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0] t_rs1, t_rs2, t_rd;
    logic t_u1, t_u2, t_mem, t_br, t_start, t_done;

    int vectors = 0;
    int miscompares = 0;

    hazard_ctrl_if #(.ADDR_W(5), .CNT_W(16)) ifa ();
    hazard_ctrl_if #(.ADDR_W(5), .CNT_W(2))  ifb ();

    assign ifa.id_rs1 = t_rs1;  assign ifb.id_rs1 = t_rs1;
    assign ifa.id_rs2 = t_rs2;  assign ifb.id_rs2 = t_rs2;
    assign ifa.id_use_rs1 = t_u1;  assign ifb.id_use_rs1 = t_u1;
    assign ifa.id_use_rs2 = t_u2;  assign ifb.id_use_rs2 = t_u2;
    assign ifa.ex_rd = t_rd;  assign ifb.ex_rd = t_rd;
    assign ifa.ex_memread = t_mem;  assign ifb.ex_memread = t_mem;
    assign ifa.ex_branch_taken = t_br;  assign ifb.ex_branch_taken = t_br;
    assign ifa.ex_mc_start = t_start;  assign ifb.ex_mc_start = t_start;
    assign ifa.mc_done = t_done;  assign ifb.mc_done = t_done;

    hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .MC_TIMEOUT(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .hz(ifa.slave));
    hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(1), .MC_TIMEOUT(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .hz(ifb.slave));

    // Reference model: per instance, remaining load-stall cycles after the hit
    // cycle, whether an MC op is outstanding and for how long, plus counters.
    int m_left[2], m_el[2], m_stall[2];
    bit m_mc[2], m_to[2];

    function automatic int ll(int i);      return (i == 0) ? 3 : 1;      endfunction
    function automatic int tmo(int i);     return (i == 0) ? 8 : 0;      endfunction
    function automatic int cmax(int i);    return (i == 0) ? 65535 : 3;  endfunction

    function automatic bit in_hit();
        return t_mem && (t_rd != 0) && ((t_u1 && t_rd == t_rs1) || (t_u2 && t_rd == t_rs2));
    endfunction

    // {pc_write, if_id_write, id_ex_write, control_sel, if_id_flush}
    function automatic logic [4:0] exp_out(int i);
        if (!rst_n)                   return 5'b00010;
        if (m_mc[i])                  return t_done ? 5'b11100 : 5'b00010;
        if (m_left[i] > 0)            return 5'b00110;
        if (t_start && !t_done)       return 5'b00010;
        if (t_br)                     return 5'b11111;
        if (in_hit())                 return 5'b00110;
        return 5'b11100;
    endfunction

    function automatic logic [29:0] exp_all();
        return {exp_out(0), exp_out(1), 16'(m_stall[0]), 2'(m_stall[1]), m_to[0], m_to[1]};
    endfunction

    function automatic logic [29:0] obs_all();
        return {ifa.pc_write, ifa.if_id_write, ifa.id_ex_write, ifa.control_sel, ifa.if_id_flush,
                ifb.pc_write, ifb.if_id_write, ifb.id_ex_write, ifb.control_sel, ifb.if_id_flush,
                ifa.stall_cycles, ifb.stall_cycles, ifa.mc_timeout, ifb.mc_timeout};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_el[i] = 0; m_stall[i] = 0; m_mc[i] = 0; m_to[i] = 0;
        end
    endfunction

    function automatic void model_update(int i);
        logic [4:0] o;
        o = exp_out(i);
        if (!o[4] && m_stall[i] < cmax(i)) m_stall[i]++;
        if (m_mc[i]) begin
            if (t_done) m_mc[i] = 0;
            else begin
                m_el[i]++;
                if (tmo(i) != 0 && m_el[i] == tmo(i)) begin
                    m_to[i] = 1;
                    m_mc[i] = 0;
                end
            end
        end else if (m_left[i] > 0) begin
            m_left[i]--;
        end else if (t_start && !t_done) begin
            m_mc[i] = 1;
            m_el[i] = 0;
        end else if (!t_br && in_hit()) begin
            m_left[i] = ll(i) - 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_update(0);
            model_update(1);
        end
        #1;
    endtask

    task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2,
                          input int rd, input bit mem, input bit br, input bit st, input bit dn);
        t_rs1 = 5'(rs1); t_rs2 = 5'(rs2); t_u1 = u1; t_u2 = u2; t_rd = 5'(rd);
        t_mem = mem; t_br = br; t_start = st; t_done = dn;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++;
        if (obs_all() !== 30'h0420_0000 >> 0 && obs_all() !== {5'b00010, 5'b00010, 16'd0, 2'd0, 2'b00}) begin
            $display("FAIL reset_state: got %h expected %h", obs_all(), {5'b00010, 5'b00010, 16'd0, 2'd0, 2'b00});
            miscompares++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        for (int c = 0; c < 5; c++) begin
            if (c == 0) set_in(5, 0, 1, 0, 5, 1, 0, 0, 0);
            else        set_in(1, 2, 1, 1, 3, 0, 0, 0, 0);
            @(negedge clk);
            vectors++;
            if (obs_all() !== exp_all()) begin
                $display("FAIL load_use cyc%0d: got %h expected %h", c, obs_all(), exp_all());
                miscompares++;
            end
            tick();
        end
        vectors++;
        if (ifa.stall_cycles !== 16'd3 || ifb.stall_cycles !== 2'd1) begin
            $display("FAIL load_use_count: got a=%0d b=%0d expected a=3 b=1", ifa.stall_cycles, ifb.stall_cycles);
            miscompares++;
        end
    endtask

    task automatic test_no_stall();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) set_in(0, 4, 1, 1, 0, 1, 0, 0, 0);
            else        set_in(3, 7, 1, 0, 7, 1, 0, 0, 0);
            @(negedge clk);
            vectors++;
            if (ifa.pc_write !== 1'b1 || ifb.pc_write !== 1'b1 || obs_all() !== exp_all()) begin
                $display("FAIL no_stall cyc%0d: got %h expected %h", c, obs_all(), exp_all());
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_load_lat();
        for (int c = 0; c < 5; c++) begin
            if (c == 0)      set_in(9, 2, 1, 1, 9, 1, 0, 0, 0);
            else if (c < 3)  set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                                    $urandom_range(0, 3), 1'($urandom), 0, 0, 0);
            else             set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            vectors++;
            if (obs_all() !== exp_all()) begin
                $display("FAIL load_lat cyc%0d: got %h expected %h", c, obs_all(), exp_all());
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_branch();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) set_in(6, 0, 1, 0, 6, 1, 1, 0, 0);
            else        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            vectors++;
            if ((c == 0 && {ifa.pc_write, ifa.if_id_flush, ifa.control_sel} !== 3'b111) ||
                obs_all() !== exp_all()) begin
                $display("FAIL branch cyc%0d: got %h expected %h", c, obs_all(), exp_all());
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_mc();
        for (int c = 0; c < 6; c++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, (c == 0), (c == 4));
            @(negedge clk);
            vectors++;
            if ((c < 4 && ifa.pc_write !== 1'b0) || (c == 4 && ifa.id_ex_write !== 1'b1) ||
                obs_all() !== exp_all()) begin
                $display("FAIL mc_done cyc%0d: got %h expected %h", c, obs_all(), exp_all());
                miscompares++;
            end
            tick();
        end
        for (int c = 0; c < 9; c++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, (c == 0), 0);
            @(negedge clk);
            vectors++;
            if (obs_all() !== exp_all()) begin
                $display("FAIL mc_timeout cyc%0d: got %h expected %h", c, obs_all(), exp_all());
                miscompares++;
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (ifa.mc_timeout !== 1'b1 || ifa.pc_write !== 1'b1 || ifb.pc_write !== 1'b0) begin
            $display("FAIL mc_timeout_flag: got to=%b pc_a=%b pc_b=%b expected 1 1 0",
                     ifa.mc_timeout, ifa.pc_write, ifb.pc_write);
            miscompares++;
        end
        t_done = 1'b1;
        tick();
        t_done = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        set_in(8, 0, 1, 0, 8, 1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (obs_all() !== {5'b00010, 5'b00010, 16'd0, 2'd0, 2'b00}) begin
            $display("FAIL reset_mid_stall: got %h expected %h", obs_all(), {5'b00010, 5'b00010, 16'd0, 2'd0, 2'b00});
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            vectors++;
            if (ifa.pc_write !== 1'b1 || obs_all() !== exp_all()) begin
                $display("FAIL post_reset cyc%0d: got %h expected %h", c, obs_all(), exp_all());
                miscompares++;
            end
        end
        tick();
    endtask

    task automatic test_saturate();
        for (int c = 0; c < 6; c++) begin
            set_in(4, 0, 1, 0, 4, 1, 0, 0, 0);
            @(negedge clk);
            vectors++;
            if (obs_all() !== exp_all()) begin
                $display("FAIL saturate cyc%0d: got %h expected %h", c, obs_all(), exp_all());
                miscompares++;
            end
            tick();
        end
        vectors++;
        if (ifb.stall_cycles !== 2'd3) begin
            $display("FAIL saturate_count: got %0d expected 3", ifb.stall_cycles);
            miscompares++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
            @(negedge clk);
            vectors++;
            if (obs_all() !== exp_all()) begin
                $display("FAIL random cyc%0d: got %h expected %h", c, obs_all(), exp_all());
                miscompares++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_load_lat();
        test_branch();
        test_mc();
        test_reset_mid_stall();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
